hamming_decoder_pipe: RTL and testbench

- Pipelined single-error-correcting decoder for the (7,4) Hamming codeword produced by hamming_encoder (ham_out[7:1]).
- Accepts one codeword per cycle over a valid/ready handshake and computes the syndrome.
- Corrects any single-bit error, extracts the 4 data bits, and keeps a saturating count of corrected words.
- Sits on the receive side of the link, between the channel and the data consumer.

---
 rtl/hamming_decoder_pipe.sv | 97 +++++++++
 tb/tb_hamming_decoder_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder_pipe.sv
// Two-stage (7,4) Hamming decoder: stage 1 captures the received word, stage 2
// computes the syndrome, corrects a single flipped bit and presents the data.
module hamming_decoder_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:1]       ham_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic             err_detected,
    output logic [2:0]       err_pos,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       s1_valid;
    logic [7:1] s1_word;
    logic       stage1_adv;
    logic       stage2_adv;
    logic [2:0] syndrome;
    logic [3:0] data_raw;
    logic [3:0] flip_mask;
    logic [3:0] data_fix;

    // Positions whose index has bit `bit_idx` set are covered by that parity check.
    function automatic logic [7:1] cover_mask(input int bit_idx);
        logic [7:1] m;
        m = '0;
        for (int p = 1; p <= 7; p++) begin
            m[p] = ((p >> bit_idx) & 1) != 0;
        end
        return m;
    endfunction

    assign stage2_adv = !out_valid || out_ready;
    assign stage1_adv = !s1_valid || stage2_adv;
    assign in_ready   = stage1_adv;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_syndrome
            assign syndrome[gi] = ^(s1_word & cover_mask(gi));
        end
    endgenerate

    // Only data positions need correcting; a parity-position hit leaves data alone.
    assign data_raw  = {s1_word[7], s1_word[6], s1_word[5], s1_word[3]};
    assign flip_mask = {syndrome == 3'd7, syndrome == 3'd6,
                        syndrome == 3'd5, syndrome == 3'd3};
    assign data_fix  = data_raw ^ flip_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else if (stage1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_word <= ham_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            data_out     <= '0;
            err_pos      <= '0;
            err_detected <= 1'b0;
        end else if (stage2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out     <= data_fix;
                err_pos      <= syndrome;
                err_detected <= |syndrome;
            end
        end
    end

    // Counts corrected words as they leave; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count <= '0;
        end else if (cnt_clr) begin
            corr_count <= '0;
        end else if (out_valid && out_ready && err_detected && corr_count != CNT_MAX) begin
            corr_count <= corr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Bench for hamming_decoder_pipe: directed vector table, stall/reset/counter
// sequences and a randomized stream scored against a nearest-codeword model.
module tb_hamming_decoder_pipe;

    localparam int CNT_W   = 2;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:1]       ham_in;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       data_out;
    logic             err_detected;
    logic [2:0]       err_pos;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_count;

    hamming_decoder_pipe #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ham_in       (ham_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .err_detected (err_detected),
        .err_pos      (err_pos),
        .cnt_clr      (cnt_clr),
        .corr_count   (corr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] pos;
        logic       det;
    } exp_t;

    typedef struct {
        logic [7:1] ham;
        exp_t       e;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    int         n_out = 0;
    int         cnt_model = 0;
    exp_t       q[$];
    exp_t       cur_exp;
    logic       held_check = 1'b0;
    logic [8:0] held_val = '0;
    logic       last_accept = 1'b0;
    logic       last_in_ready = 1'b0;
    logic [3:0] last_data = '0;
    vec_t       tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:1] encode(input logic [3:0] d);
        logic [7:1] h;
        h[3] = d[0];
        h[5] = d[1];
        h[6] = d[2];
        h[7] = d[3];
        h[1] = d[0] ^ d[1] ^ d[3];
        h[2] = d[0] ^ d[2] ^ d[3];
        h[4] = d[1] ^ d[2] ^ d[3];
        return h;
    endfunction

    function automatic logic [7:1] flip(input logic [7:1] h, input int p);
        logic [7:1] r;
        r = h;
        if (p != 0) r[p] = ~r[p];
        return r;
    endfunction

    // Nearest codeword by exhaustive search: the code is perfect, so exactly one
    // (data, flipped position) pair reproduces any received word.
    function automatic exp_t ref_decode(input logic [7:1] h);
        exp_t r;
        r = '0;
        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 8; p++) begin
                if (flip(encode(4'(d)), p) == h) begin
                    r.data = 4'(d);
                    r.pos  = 3'(p);
                    r.det  = (p != 0);
                end
            end
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [7:1] h, input logic [3:0] d,
                                input logic [2:0] p, input logic det);
        vec_t v;
        v.ham    = h;
        v.e.data = d;
        v.e.pos  = p;
        v.e.det  = det;
        return v;
    endfunction

    // One clock cycle: sample mid-cycle, score handshakes, advance, check counter.
    task automatic tick();
        exp_t e;
        logic hs;
        logic got_det;
        #1;
        if (held_check)
            chk("hold_stable", 32'({out_valid, data_out, err_pos, err_detected}), 32'(held_val));
        last_accept   = in_valid && in_ready;
        last_in_ready = in_ready;
        last_data     = data_out;
        if (last_accept) q.push_back(cur_exp);
        hs      = out_valid && out_ready;
        got_det = 1'b0;
        if (hs) begin
            n_out++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out: got data %0h with no word outstanding", data_out);
            end else begin
                e = q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("err_pos", 32'(err_pos), 32'(e.pos));
                chk("err_detected", 32'(err_detected), 32'(e.det));
                got_det = e.det;
                $display("out data=%h pos=%0d det=%0b cnt=%0d", data_out, err_pos, err_detected, corr_count);
            end
        end
        if (cnt_clr) cnt_model = 0;
        else if (got_det && cnt_model != CNT_TOP) cnt_model++;
        held_check = out_valid && !out_ready;
        held_val   = {out_valid, data_out, err_pos, err_detected};
        @(posedge clk);
        #1;
        chk("corr_count", 32'(corr_count), 32'(cnt_model));
    endtask

    initial begin
        logic [7:1] bp_words[4];
        logic [3:0] d;
        int         p;
        int         sent;
        int         c;
        int         n_before;

        tbl[0] = mk(7'b0110011, 4'b0110, 3'd0, 1'b0);
        tbl[1] = mk(7'b0100011, 4'b0110, 3'd5, 1'b1);
        tbl[2] = mk(7'b1100111, 4'b1101, 3'd1, 1'b1);
        tbl[3] = mk(7'b0000000, 4'b0000, 3'd0, 1'b0);
        tbl[4] = mk(7'b1111111, 4'b1111, 3'd0, 1'b0);
        tbl[5] = mk(7'b1000000, 4'b0000, 3'd7, 1'b1);
        tbl[6] = mk(7'b1111101, 4'b1111, 3'd2, 1'b1);
        tbl[7] = mk(7'b0110111, 4'b0110, 3'd3, 1'b1);

        rst_n = 1'b0; in_valid = 1'b0; ham_in = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        cur_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_data_out", 32'(data_out), 32'(0));
        chk("rst_err", 32'({err_pos, err_detected}), 32'(0));
        chk("rst_count", 32'(corr_count), 32'(0));
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'(1));

        // Directed vectors, one at a time, checking the exact 2-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            ham_in   = tbl[i].ham;
            cur_exp  = tbl[i].e;
            tick();
            in_valid = 1'b0;
            chk("lat_not_1", 32'(out_valid), 32'(0));
            tick();
            chk("lat_is_2", 32'(out_valid), 32'(1));
            tick();
        end

        // Backpressure: four words while the consumer stalls for four cycles.
        bp_words[0] = 7'b0110011; bp_words[1] = 7'b0100011;
        bp_words[2] = 7'b1100111; bp_words[3] = 7'b0011001;
        sent = 0; c = 0; n_before = n_out;
        while (!(sent == 4 && q.size() == 0) && c < 40) begin
            out_ready = (c >= 4);
            in_valid  = (sent < 4);
            if (sent < 4) begin
                ham_in  = bp_words[sent];
                cur_exp = ref_decode(bp_words[sent]);
            end
            tick();
            if (last_accept) sent++;
            if (c == 2) begin
                chk("bp_in_ready_low", 32'(last_in_ready), 32'(0));
                chk("bp_first_held", 32'(last_data), 32'(4'b0110));
            end
            c++;
        end
        in_valid = 1'b0;
        chk("bp_delivered", 32'(n_out - n_before), 32'(4));

        // Saturation: five corrected words into a 2-bit counter.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_to_zero", 32'(corr_count), 32'(0));
        out_ready = 1'b1;
        sent = 0; c = 0;
        while (!(sent == 5 && q.size() == 0) && c < 40) begin
            in_valid = (sent < 5);
            d = 4'($urandom_range(0, 15));
            p = $urandom_range(1, 7);
            ham_in  = flip(encode(d), p);
            cur_exp = '{data: d, pos: 3'(p), det: 1'b1};
            tick();
            if (last_accept) sent++;
            c++;
        end
        in_valid = 1'b0;
        chk("sat_count", 32'(corr_count), 32'(CNT_TOP));

        // Asynchronous reset while both stages hold words and the output stalls.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ham_in  = tbl[i + 1].ham;
            cur_exp = tbl[i + 1].e;
            tick();
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_data_out", 32'(data_out), 32'(0));
        chk("mid_rst_err", 32'({err_pos, err_detected}), 32'(0));
        chk("mid_rst_count", 32'(corr_count), 32'(0));
        q.delete();
        cnt_model  = 0;
        held_check = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 32'(1));
        chk("mid_rel_flushed", 32'(out_valid), 32'(0));

        // Clear coinciding with a corrected-word accept.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        ham_in    = 7'b0100011;
        cur_exp   = ref_decode(ham_in);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("one_corrected", 32'(corr_count), 32'(1));
        in_valid = 1'b1;
        ham_in   = 7'b0110111;
        cur_exp  = ref_decode(ham_in);
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_word_ready", 32'(out_valid && err_detected), 32'(1));
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_priority", 32'(corr_count), 32'(0));

        // Randomized traffic with random stalls and occasional clears.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 19) == 0);
            d = 4'($urandom_range(0, 15));
            p = $urandom_range(0, 7);
            ham_in  = flip(encode(d), p);
            cur_exp = '{data: d, pos: 3'(p), det: (p != 0)};
            tick();
        end
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("drain_empty", 32'(q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
